hood_mode_controller: RTL and testbench

- Top-level mode sequencer for the exhaust hood. Turns single-cycle button pulses into the `current_mode` bus.
- Per-mode event/timing modules consume `current_mode`.
- Enforces the power, standby, fan-level, hurricane and self-clean rules.
- Runs the 1-second prescaler and the countdowns for the timed modes (hurricane, hurricane-exit, self-clean).

---
 rtl/hood_mode_controller.sv | 126 ++++++++++++
 tb/tb_hood_mode_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hood_mode_controller.sv
// Exhaust hood mode sequencer: button pulses to mode bus,
// with a 1 s prescaler and countdowns for the timed modes.
module hood_mode_controller #(
  parameter int MODE_WIDTH    = 3,
  parameter int MAX_WIDTH     = 32,
  parameter int COUNTER_1SEC  = 100_000_000,
  parameter int HURRICANE_SEC = 60,
  parameter int EXIT_SEC      = 60,
  parameter int CLEAN_SEC     = 180
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  power_btn,
  input  logic                  mode1_btn,
  input  logic                  mode2_btn,
  input  logic                  mode3_btn,
  input  logic                  clean_btn,
  output logic [MODE_WIDTH-1:0] current_mode,
  output logic [MAX_WIDTH-1:0]  countdown,
  output logic                  hurricane_used,
  output logic                  mode_changed
);

  localparam int PW = $clog2(COUNTER_1SEC + 1);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_STBY   = 3'd1,
    S_FIRST  = 3'd2,
    S_SECOND = 3'd3,
    S_THIRD  = 3'd4,
    S_EXIT   = 3'd5,
    S_CLEAN  = 3'd6
  } state_e;

  state_e               state_q, state_d;
  logic [MAX_WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]        pre_q, pre_d;
  logic                 used_q, used_d;
  logic                 chg_q, chg_d;
  logic                 tick, timeout;

  assign tick    = (pre_q == PW'(COUNTER_1SEC));
  assign timeout = tick && (cnt_q == MAX_WIDTH'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_OFF: begin
        if (power_btn) state_d = S_STBY;
      end
      S_STBY: begin
        if (power_btn)                    state_d = S_OFF;
        else if (mode3_btn && !used_q)    state_d = S_THIRD;
        else if (mode2_btn)               state_d = S_SECOND;
        else if (mode1_btn)               state_d = S_FIRST;
        else if (clean_btn)               state_d = S_CLEAN;
      end
      S_FIRST: begin
        if (power_btn)                    state_d = S_STBY;
        else if (mode3_btn && !used_q)    state_d = S_THIRD;
        else if (mode2_btn)               state_d = S_SECOND;
      end
      S_SECOND: begin
        if (power_btn)                    state_d = S_STBY;
        else if (mode3_btn && !used_q)    state_d = S_THIRD;
        else if (mode1_btn)               state_d = S_FIRST;
      end
      S_THIRD: begin
        if (timeout)        state_d = S_SECOND;
        else if (power_btn) state_d = S_EXIT;
      end
      S_EXIT: begin
        if (timeout) state_d = S_STBY;
      end
      S_CLEAN: begin
        // a power press beats a coincident timeout here
        if (power_btn)    state_d = S_OFF;
        else if (timeout) state_d = S_STBY;
      end
      default: state_d = S_OFF;
    endcase
  end

  always_comb begin
    chg_d  = (state_d != state_q);
    used_d = used_q;
    cnt_d  = cnt_q;
    pre_d  = tick ? '0 : pre_q + PW'(1);
    if (chg_d) begin
      pre_d = '0;
      unique case (state_d)
        S_THIRD: cnt_d = MAX_WIDTH'(HURRICANE_SEC);
        S_EXIT:  cnt_d = MAX_WIDTH'(EXIT_SEC);
        S_CLEAN: cnt_d = MAX_WIDTH'(CLEAN_SEC);
        default: cnt_d = '0;
      endcase
      if (state_d == S_THIRD) used_d = 1'b1;
      if (state_d == S_OFF)   used_d = 1'b0;
    end else if (tick && cnt_q != '0) begin
      cnt_d = cnt_q - MAX_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      pre_q   <= '0;
      used_q  <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      used_q  <= used_d;
      chg_q   <= chg_d;
    end
  end

  assign current_mode   = MODE_WIDTH'(state_q);
  assign countdown      = cnt_q;
  assign hurricane_used = used_q;
  assign mode_changed   = chg_q;

endmodule

// File: tb/tb_hood_mode_controller.sv
// Bench for hood_mode_controller: directed scenarios plus
// randomized pulses against a table-driven reference model.
module tb_hood_mode_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        power_btn = 0, mode1_btn = 0, mode2_btn = 0;
  logic        mode3_btn = 0, clean_btn = 0;
  logic [2:0]  current_mode;
  logic [31:0] countdown;
  logic        hurricane_used, mode_changed;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hood_mode_controller #(
    .MODE_WIDTH(3), .MAX_WIDTH(32), .COUNTER_1SEC(4),
    .HURRICANE_SEC(3), .EXIT_SEC(2), .CLEAN_SEC(2)
  ) dut (
    .clk(clk), .rst(rst),
    .power_btn(power_btn), .mode1_btn(mode1_btn),
    .mode2_btn(mode2_btn), .mode3_btn(mode3_btn),
    .clean_btn(clean_btn),
    .current_mode(current_mode), .countdown(countdown),
    .hurricane_used(hurricane_used), .mode_changed(mode_changed)
  );

  // Reference model: button order power, mode3, mode2, mode1, clean.
  // -1 marks a button that does nothing in that mode.
  int tgt [0:6][0:4] = '{
    '{ 1, -1, -1, -1, -1},
    '{ 0,  4,  3,  2,  6},
    '{ 1,  4,  3, -1, -1},
    '{ 1,  4, -1,  2, -1},
    '{ 5, -1, -1, -1, -1},
    '{-1, -1, -1, -1, -1},
    '{ 0, -1, -1, -1, -1}
  };
  int dur   [0:6] = '{0, 0, 0, 0, 3, 2, 2};
  int after [0:6] = '{0, 0, 0, 0, 3, 1, 1};

  int m_mode = 0, m_cd = 0, m_ph = 0, m_used = 0, m_chg = 0;

  task automatic model(input bit p, m1, m2, m3, c, r);
    bit b [0:4];
    bit tick, found;
    int nxt;
    if (r) begin
      m_mode = 0; m_cd = 0; m_ph = 0; m_used = 0; m_chg = 0;
      return;
    end
    b[0] = p; b[1] = m3; b[2] = m2; b[3] = m1; b[4] = c;
    tick = (m_ph == 4);
    nxt = m_mode;
    found = 0;
    if (m_mode == 6 && p) nxt = 0;
    else if (tick && m_cd == 1 && dur[m_mode] != 0) nxt = after[m_mode];
    else
      for (int k = 0; k < 5; k++)
        if (!found && b[k] && tgt[m_mode][k] >= 0 && !(k == 1 && m_used != 0)) begin
          nxt = tgt[m_mode][k];
          found = 1;
        end
    if (nxt != m_mode) begin
      m_cd = dur[nxt]; m_ph = 0; m_chg = 1;
      if (nxt == 4) m_used = 1;
      if (nxt == 0) m_used = 0;
      m_mode = nxt;
    end else begin
      m_chg = 0;
      if (tick && m_cd > 0) m_cd--;
      m_ph = tick ? 0 : m_ph + 1;
    end
  endtask

  task automatic step(input bit p, m1, m2, m3, c, r);
    power_btn = p; mode1_btn = m1; mode2_btn = m2;
    mode3_btn = m3; clean_btn = c; rst = r;
    @(posedge clk);
    model(p, m1, m2, m3, c, r);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    step(0, 0, 0, 0, 0, 1);
    tests++;
    if (current_mode !== 3'd0 || countdown !== 32'd0 ||
        hurricane_used !== 1'b0 || mode_changed !== 1'b0) begin
      fails++;
      $display("FAIL reset mode=%0d cd=%0d used=%b chg=%b exp 0/0/0/0",
               current_mode, countdown, hurricane_used, mode_changed);
    end
  endtask

  task automatic test_power;
    step(1, 0, 0, 0, 0, 0);
    tests++;
    if (current_mode !== 3'd1 || mode_changed !== 1'b1) begin
      fails++;
      $display("FAIL power_on mode=%0d chg=%b exp 1/1", current_mode, mode_changed);
    end
    idle(1);
    tests++;
    if (current_mode !== 3'd1 || mode_changed !== 1'b0) begin
      fails++;
      $display("FAIL power_hold mode=%0d chg=%b exp 1/0", current_mode, mode_changed);
    end
    step(1, 0, 0, 0, 0, 0);
    tests++;
    if (current_mode !== 3'd0 || mode_changed !== 1'b1) begin
      fails++;
      $display("FAIL power_off mode=%0d chg=%b exp 0/1", current_mode, mode_changed);
    end
  endtask

  task automatic test_levels;
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    tests++;
    if (current_mode !== 3'd2) begin
      fails++; $display("FAIL level1 mode=%0d exp 2", current_mode);
    end
    step(0, 0, 1, 0, 0, 0);
    tests++;
    if (current_mode !== 3'd3) begin
      fails++; $display("FAIL level2 mode=%0d exp 3", current_mode);
    end
    step(0, 0, 0, 1, 0, 0);
    tests++;
    if (current_mode !== 3'd4 || countdown !== 32'd3 || hurricane_used !== 1'b1) begin
      fails++;
      $display("FAIL hurricane_entry mode=%0d cd=%0d used=%b exp 4/3/1",
               current_mode, countdown, hurricane_used);
    end
    idle(14);
    tests++;
    if (current_mode !== 3'd4 || countdown !== 32'd1) begin
      fails++;
      $display("FAIL hurricane_last mode=%0d cd=%0d exp 4/1", current_mode, countdown);
    end
    idle(1);
    tests++;
    if (current_mode !== 3'd3 || countdown !== 32'd0 || mode_changed !== 1'b1) begin
      fails++;
      $display("FAIL hurricane_timeout mode=%0d cd=%0d chg=%b exp 3/0/1",
               current_mode, countdown, mode_changed);
    end
  endtask

  task automatic test_hurricane_single;
    step(0, 0, 0, 1, 0, 0);
    tests++;
    if (current_mode !== 3'd3 || mode_changed !== 1'b0) begin
      fails++;
      $display("FAIL hurricane_reuse mode=%0d chg=%b exp 3/0", current_mode, mode_changed);
    end
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    tests++;
    if (current_mode !== 3'd0 || hurricane_used !== 1'b0) begin
      fails++;
      $display("FAIL off_clears mode=%0d used=%b exp 0/0", current_mode, hurricane_used);
    end
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    tests++;
    if (current_mode !== 3'd4) begin
      fails++; $display("FAIL hurricane_again mode=%0d exp 4", current_mode);
    end
  endtask

  task automatic test_exit;
    step(1, 0, 0, 0, 0, 0);
    tests++;
    if (current_mode !== 3'd5 || countdown !== 32'd2) begin
      fails++;
      $display("FAIL exit_entry mode=%0d cd=%0d exp 5/2", current_mode, countdown);
    end
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(4);
    tests++;
    if (current_mode !== 3'd5 || countdown !== 32'd1) begin
      fails++;
      $display("FAIL exit_ignores mode=%0d cd=%0d exp 5/1", current_mode, countdown);
    end
    idle(1);
    tests++;
    if (current_mode !== 3'd1 || countdown !== 32'd0) begin
      fails++;
      $display("FAIL exit_timeout mode=%0d cd=%0d exp 1/0", current_mode, countdown);
    end
  endtask

  task automatic test_priority_clean;
    step(0, 1, 1, 0, 1, 0);
    tests++;
    if (current_mode !== 3'd3) begin
      fails++; $display("FAIL priority mode=%0d exp 3", current_mode);
    end
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    tests++;
    if (current_mode !== 3'd6 || countdown !== 32'd2) begin
      fails++;
      $display("FAIL clean_entry mode=%0d cd=%0d exp 6/2", current_mode, countdown);
    end
    idle(10);
    tests++;
    if (current_mode !== 3'd1 || countdown !== 32'd0) begin
      fails++;
      $display("FAIL clean_timeout mode=%0d cd=%0d exp 1/0", current_mode, countdown);
    end
  endtask

  task automatic test_abort;
    step(0, 0, 0, 0, 1, 0);
    idle(9);
    tests++;
    if (current_mode !== 3'd6 || countdown !== 32'd1) begin
      fails++;
      $display("FAIL clean_last mode=%0d cd=%0d exp 6/1", current_mode, countdown);
    end
    step(1, 0, 0, 0, 0, 0);
    tests++;
    if (current_mode !== 3'd0 || countdown !== 32'd0) begin
      fails++;
      $display("FAIL clean_power_wins mode=%0d cd=%0d exp 0/0", current_mode, countdown);
    end
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(3);
    step(0, 0, 0, 0, 0, 1);
    tests++;
    if (current_mode !== 3'd0 || countdown !== 32'd0 ||
        hurricane_used !== 1'b0 || mode_changed !== 1'b0) begin
      fails++;
      $display("FAIL rst_abort mode=%0d cd=%0d used=%b chg=%b exp 0/0/0/0",
               current_mode, countdown, hurricane_used, mode_changed);
    end
  endtask

  task automatic test_random;
    bit p, m1, m2, m3, c, r;
    for (int i = 0; i < 4000; i++) begin
      p  = ($urandom_range(0, 15) == 0);
      m1 = ($urandom_range(0, 9) == 0);
      m2 = ($urandom_range(0, 9) == 0);
      m3 = ($urandom_range(0, 9) == 0);
      c  = ($urandom_range(0, 9) == 0);
      r  = ($urandom_range(0, 299) == 0);
      step(p, m1, m2, m3, c, r);
      tests++;
      if (current_mode !== 3'(m_mode) || countdown !== 32'(m_cd) ||
          hurricane_used !== 1'(m_used) || mode_changed !== 1'(m_chg)) begin
        fails++;
        $display("FAIL random cyc=%0d got %0d/%0d/%b/%b exp %0d/%0d/%0d/%0d",
                 i, current_mode, countdown, hurricane_used, mode_changed,
                 m_mode, m_cd, m_used, m_chg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_power();
    test_levels();
    test_hurricane_single();
    test_exit();
    test_priority_clean();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
